// File: rtl/i2c_pkg.sv
// Shared FSM state type and transfer geometry for the I2C/SCCB writer.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BIT,
        STOP
    } state_t;

    localparam int SLOTS_PER_XFER   = 27;
    localparam int SLOTS_PER_BYTE   = 9;
    localparam int QUARTERS_PER_BIT = 4;

    // The ninth slot of every byte belongs to the slave.
    function automatic logic is_ack_slot(input logic [4:0] slot);
        return (slot % 5'(SLOTS_PER_BYTE)) == 5'(SLOTS_PER_BYTE - 1);
    endfunction

endpackage

// File: rtl/i2c_sccb_writer_if.sv
// Host-side handshake of the SCCB writer; ack_err exists only with I2C_ACK_CHECK_EN.
interface i2c_sccb_writer_if;

    logic        sendit;
    logic [23:0] send_dat;
    logic        scl;
    logic [6:0]  send_count_out;
`ifdef I2C_ACK_CHECK_EN
    logic        ack_err;

    modport master (input sendit, send_dat, output scl, send_count_out, ack_err);
    modport slave  (output sendit, send_dat, input scl, send_count_out, ack_err);
`else
    modport master (input sendit, send_dat, output scl, send_count_out);
    modport slave  (output sendit, send_dat, input scl, send_count_out);
`endif

endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period divider: one-cycle tick every CLK_DIV clocks while enabled, held at 0 otherwise.
module i2c_qtick #(
    parameter int CLK_DIV = 62
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = (cnt == W'(CLK_DIV - 1));
    assign tick = en && !clr && wrap;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_sccb_writer.sv
// SCCB register writer: START, three bytes each followed by an ACK slot, STOP.
// Define I2C_ACK_CHECK_EN to sample ACK slots, flag NACK on ack_err and abort early.
module i2c_sccb_writer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 62
) (
    input  logic                meg25,
    input  logic                rst,
    i2c_sccb_writer_if.master   bus,
    inout  wire                 sda
);

    state_t      state;
    logic        sendit_q;
    logic [23:0] shift;
    logic [4:0]  slot;
    logic [1:0]  quarter;
    logic [6:0]  count;
    logic        scl_r;
    logic        sda_low;
    logic        scl_nxt;
    logic        sda_low_nxt;
    logic        tick;
    logic        start;
    logic        last_slot;
`ifdef I2C_ACK_CHECK_EN
    logic        ack_err_r;
`endif

    assign start = bus.sendit && !sendit_q && (state == IDLE);

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk  (meg25),
        .rst  (rst),
        .en   (state != IDLE),
        .clr  (start),
        .tick (tick)
    );

`ifdef I2C_ACK_CHECK_EN
    assign last_slot = (slot == 5'(SLOTS_PER_XFER - 1)) || ack_err_r;
`else
    assign last_slot = (slot == 5'(SLOTS_PER_XFER - 1));
`endif

    // Pin levels for the current quarter; they reach the pads through scl_r/sda_low one clock later.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
        unique case (state)
            IDLE: begin
            end
            START: begin
                scl_nxt     = (quarter == 2'd0);
                sda_low_nxt = 1'b1;
            end
            BIT: begin
                scl_nxt     = quarter[1];
                sda_low_nxt = !is_ack_slot(slot) && !shift[23];
            end
            STOP: begin
                scl_nxt     = (quarter == 2'd1);
                sda_low_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sendit_q  <= 1'b0;
            shift     <= '0;
            slot      <= '0;
            quarter   <= '0;
            count     <= '0;
            scl_r     <= 1'b1;
            sda_low   <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
            ack_err_r <= 1'b0;
`endif
        end else begin
            sendit_q <= bus.sendit;
            scl_r    <= scl_nxt;
            sda_low  <= sda_low_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= START;
                        shift     <= bus.send_dat;
                        slot      <= '0;
                        quarter   <= '0;
                        count     <= '0;
`ifdef I2C_ACK_CHECK_EN
                        ack_err_r <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        quarter <= (quarter == 2'd1) ? 2'd0 : quarter + 2'd1;
                        if (quarter == 2'd1) state <= BIT;
                    end
                end
                BIT: begin
                    if (tick) begin
                        quarter <= quarter + 2'd1;
`ifdef I2C_ACK_CHECK_EN
                        if (quarter == 2'd2 && is_ack_slot(slot) && sda)
                            ack_err_r <= 1'b1;
`endif
                        if (quarter == 2'(QUARTERS_PER_BIT - 1)) begin
                            count <= count + 7'd1;
                            if (!is_ack_slot(slot)) shift <= {shift[22:0], 1'b0};
                            if (last_slot) state <= STOP;
                            else           slot  <= slot + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        quarter <= (quarter == 2'd1) ? 2'd0 : quarter + 2'd1;
                        if (quarter == 2'd1) state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.scl            = scl_r;
    assign bus.send_count_out = count;
    assign sda                = sda_low ? 1'b0 : 1'bz;
`ifdef I2C_ACK_CHECK_EN
    assign bus.ack_err        = ack_err_r;
`endif

endmodule

// File: tb/tb_i2c_sccb_writer.sv
// Bench for i2c_sccb_writer: quarter-schedule model compared every clock plus directed literal checks.
module tb_i2c_sccb_writer;

    localparam int D = 4;

    logic meg25 = 1'b0;
    logic rst;
    logic slave_drive = 1'b0;
    wire  sda;

    assign sda = slave_drive ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_sccb_writer_if bus ();

    i2c_sccb_writer #(.CLK_DIV(D)) dut (
        .meg25 (meg25),
        .rst   (rst),
        .bus   (bus),
        .sda   (sda)
    );

    always #20 meg25 = ~meg25;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction described by its start edge, word, slot count and slave behaviour.
    bit          slave_ack;
    bit          m_has_tx = 0;
    bit          m_prev   = 0;
    bit          m_slave  = 0;
    int          m_n      = 0;
    int          m_nslots = 27;
    int          m_ack_edge = -1;
    logic [23:0] m_word   = '0;

    function automatic int total_edges();
        return (4 + 4 * m_nslots) * D;
    endfunction

    function automatic bit model_idle();
        return !m_has_tx || (m_n >= total_edges() + 1);
    endfunction

    // Pins lag the transaction schedule by one clock: quarter p is on the pads for edges 1+p*D .. (p+1)*D.
    task automatic expect_pins(output logic scl_e, output logic low_e, output logic ack_e);
        int p, s, q, bq;
        scl_e = 1'b1; low_e = 1'b0; ack_e = 1'b0;
        if (m_has_tx && m_n >= 1) begin
            p  = (m_n - 1) / D;
            bq = 4 * m_nslots;
            if (p < 2) begin
                scl_e = (p == 0); low_e = 1'b1;
            end else if (p < 2 + bq) begin
                s = (p - 2) / 4; q = (p - 2) % 4;
                scl_e = (q >= 2);
                if (s % 9 == 8) ack_e = 1'b1;
                else            low_e = ~m_word[23 - 8 * (s / 9) - (s % 9)];
            end else if (p < 4 + bq) begin
                scl_e = (p == 3 + bq); low_e = 1'b1;
            end
        end
    endtask

    function automatic int expect_count();
        int qd, sd;
        if (!m_has_tx) return 0;
        qd = m_n / D;
        sd = (qd < 2) ? 0 : (qd - 2) / 4;
        return (sd < m_nslots) ? sd : m_nslots;
    endfunction

    initial begin : compare
        logic scl_e, low_e, ack_e;
        forever begin
            @(posedge meg25);
            if (rst) begin
                m_has_tx = 0;
                m_prev   = 0;
            end else begin
                if (m_has_tx && m_n < 1000000) m_n++;
                if (bus.sendit && !m_prev && model_idle()) begin
                    m_has_tx = 1;
                    m_n      = 0;
                    m_word   = bus.send_dat;
                    m_slave  = slave_ack;
                    m_nslots = 27;
                    m_ack_edge = -1;
`ifdef I2C_ACK_CHECK_EN
                    if (!slave_ack) begin
                        m_nslots   = 9;
                        m_ack_edge = (2 + 4 * 8 + 3) * D;
                    end
`endif
                end
                m_prev = bus.sendit;
            end
            #1;
            expect_pins(scl_e, low_e, ack_e);
            slave_drive = m_slave && ack_e;
            #1;
            check("scl", 32'(bus.scl), 32'(scl_e));
            check("sda", 32'(sda), 32'((low_e || slave_drive) ? 1'b0 : 1'b1));
            check("count", 32'(bus.send_count_out), 32'(expect_count()));
`ifdef I2C_ACK_CHECK_EN
            check("ack_err", 32'(bus.ack_err),
                  32'(m_has_tx && m_ack_edge >= 0 && m_n >= m_ack_edge));
`endif
        end
    end

    task automatic start_tx(input logic [23:0] w);
        @(negedge meg25); bus.sendit = 1'b0;
        @(negedge meg25); bus.send_dat = w; bus.sendit = 1'b1;
        @(posedge meg25);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge meg25);
            if (model_idle()) break;
        end
        check("wait_idle", 32'(model_idle()), 32'd1);
    endtask

    bit ack_default;

    initial begin : stimulus
        logic        prev_scl;
        int          rises;
        logic [26:0] bits;
        logic [26:0] exp_bits;
        bit          hit;

`ifdef I2C_ACK_CHECK_EN
        ack_default = 1;
        exp_bits    = 27'b010000100_000110100_010111000;
`else
        ack_default = 0;
        exp_bits    = 27'b010000101_000110101_010111001;
`endif
        slave_ack    = ack_default;
        rst          = 1'b1;
        bus.sendit   = 1'b0;
        bus.send_dat = '0;

        // Reset state, then quiet bus for 100 clocks.
        repeat (3) @(negedge meg25);
        check("rst_scl", 32'(bus.scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_count", 32'(bus.send_count_out), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge meg25);
        check("quiet_scl", 32'(bus.scl), 32'd1);
        check("quiet_sda", 32'(sda), 32'd1);

        // All-ones word with sendit held high: START, released bits, STOP at 448 clocks.
        start_tx(24'hFFFFFF);
        #2;
        check("e0_sda", 32'(sda), 32'd1);
        @(posedge meg25); #2;
        check("start_sda", 32'(sda), 32'd0);
        check("start_scl", 32'(bus.scl), 32'd1);
        repeat (447) @(posedge meg25);
        #2;
        check("stop_q1_sda", 32'(sda), 32'd0);
        check("stop_q1_scl", 32'(bus.scl), 32'd1);
        @(posedge meg25); #2;
        check("stop_rel_sda", 32'(sda), 32'd1);
        check("done_count", 32'(bus.send_count_out), 32'd27);
        repeat (2000) @(negedge meg25);
        check("no_retrig_count", 32'(bus.send_count_out), 32'd27);
        check("no_retrig_scl", 32'(bus.scl), 32'd1);

        // Bit order sampled at each SCL rise.
        start_tx(24'h421A5C);
        prev_scl = 1'b1; rises = 0; bits = '0;
        repeat (460) begin
            @(posedge meg25); #2;
            if (rises == 2) bus.sendit = 1'b0;
            if (bus.scl && !prev_scl) begin
                if (rises < 27) bits[26 - rises] = sda;
                rises++;
            end
            prev_scl = bus.scl;
        end
        check("rise_bits", 32'(bits), 32'(exp_bits));
        check("rise_count", 32'(rises), 32'd28);

        // Pulse mid-transaction is ignored; pulse after STOP restarts at count 0.
        start_tx(24'h3C_A5_0F);
        repeat (3) @(negedge meg25);
        bus.sendit = 1'b0;
        repeat (200) @(negedge meg25);
        bus.sendit = 1'b1;
        repeat (5) @(negedge meg25);
        bus.sendit = 1'b0;
        wait_idle(1000);
        start_tx(24'h3C_A5_0F);
        #2;
        check("restart_count", 32'(bus.send_count_out), 32'd0);
        wait_idle(1000);
        check("second_count", 32'(bus.send_count_out), 32'd27);

        // Async reset at slot 10, then a clean restart.
        start_tx(24'h60_0D_B7);
        hit = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge meg25);
            hit = (bus.send_count_out == 7'd10);
        end
        check("reach_slot10", 32'(hit), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_scl", 32'(bus.scl), 32'd1);
        check("mid_rst_sda", 32'(sda), 32'd1);
        check("mid_rst_count", 32'(bus.send_count_out), 32'd0);
        repeat (3) @(negedge meg25);
        bus.sendit = 1'b0;
        @(negedge meg25); rst = 1'b0;
        repeat (5) @(negedge meg25);
        start_tx(24'h60_0D_B7);
        wait_idle(1000);
        check("post_rst_count", 32'(bus.send_count_out), 32'd27);

`ifdef I2C_ACK_CHECK_EN
        // No slave: NACK after the address byte. Slave acking: full transfer.
        slave_ack = 0;
        start_tx(24'h42_1A_5C);
        wait_idle(1000);
        check("nack_err", 32'(bus.ack_err), 32'd1);
        check("nack_count", 32'(bus.send_count_out), 32'd9);
        slave_ack = 1;
        start_tx(24'h42_1A_5C);
        wait_idle(1000);
        check("ack_err_clear", 32'(bus.ack_err), 32'd0);
        check("ack_count", 32'(bus.send_count_out), 32'd27);
`endif

        // Randomized words, slave behaviour, late data changes and stray pulses.
        for (int t = 0; t < 8; t++) begin
            slave_ack = ($urandom_range(0, 1) == 1);
            start_tx(24'($urandom));
            repeat ($urandom_range(1, 4)) @(negedge meg25);
            bus.send_dat = 24'($urandom);
            bus.sendit   = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(20, 300)) @(negedge meg25);
                bus.sendit = 1'b1;
                repeat (3) @(negedge meg25);
                bus.sendit = 1'b0;
            end
            wait_idle(1500);
            wait_idle(1500);
            repeat ($urandom_range(1, 20)) @(negedge meg25);
        end

        repeat (10) @(negedge meg25);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
